// File: rtl/child_event_gather_pkg.sv
// Shared defaults and the buffered event entry for child_event_gather.
// The entry layout is {index, data}, index in the upper bits.
package child_event_gather_pkg;

  localparam int NUM_CHILD_DEF  = 5;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int IDX_W          = $clog2(NUM_CHILD_DEF);

  typedef struct packed {
    logic [IDX_W-1:0]      index;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/child_event_fifo.sv
// Small synchronous FIFO with full/empty flags.
// The head reads as zero while empty so nothing stale leaks upward.
module child_event_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/child_event_gather.sv
// Round-robin gatherer: one child event per cycle into a FIFO,
// drained by the parent, with a wrapping delivered-event counter.
module child_event_gather
  import child_event_gather_pkg::*;
#(
  parameter int NUM_CHILD  = NUM_CHILD_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int IW = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHILD-1:0]             child_valid,
  input  logic [NUM_CHILD-1:0][DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]             child_ready,
  output logic                             up_valid,
  input  logic                             up_ready,
  output logic [IW-1:0]                    up_index,
  output logic [DATA_W-1:0]                up_data,
  output logic [15:0]                      event_count
);

  localparam int EW = IW + DATA_W;

  logic [IW-1:0]        rr_ptr;
  logic [NUM_CHILD-1:0] grant;
  logic [IW-1:0]        gidx;
  logic                 found;
  int                   j;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [EW-1:0]        wdata;
  logic [EW-1:0]        rdata;

  // Round-robin search from rr_ptr upward, first valid child wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      j = (int'(rr_ptr) + k) % NUM_CHILD;
      if (!found && child_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = IW'(j);
      end
    end
  end

  assign child_ready = full ? '0 : grant;
  assign push        = |child_ready;
  assign wdata       = {gidx, child_data[gidx]};
  assign up_valid    = ~empty;
  assign pop         = up_valid & up_ready;
  assign up_index    = rdata[EW-1:DATA_W];
  assign up_data     = rdata[DATA_W-1:0];

  child_event_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Pointer moves past the granted child; holds when nothing granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gidx == IW'(NUM_CHILD - 1)) ? '0 : gidx + 1'b1;
    end
  end

  // Count every parent transfer, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= '0;
    end else if (pop) begin
      event_count <= event_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_child_event_gather.sv
// Scoreboard bench for child_event_gather: a reference arbiter
// predicts grants and queues expected entries for the parent side.
module tb_child_event_gather;
  import child_event_gather_pkg::*;

  localparam int N = NUM_CHILD_DEF;
  localparam int D = FIFO_DEPTH_DEF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         cv;
  logic [N-1:0][7:0]    cd;
  logic [N-1:0]         child_ready;
  logic                 up_valid;
  logic                 ur;
  logic [IDX_W-1:0]     up_index;
  logic [7:0]           up_data;
  logic [15:0]          event_count;

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];
  int     rr = 0;
  int     xfers = 0;
  logic [15:0] cnt = 16'd0;
  bit     fresh = 1'b1;

  child_event_gather dut (
    .clk         (clk),
    .rst         (rst),
    .child_valid (cv),
    .child_data  (cd),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_ready    (ur),
    .up_index    (up_index),
    .up_data     (up_data),
    .event_count (event_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are set right after a negedge; compare #1 later, then
  // advance the model to what the next posedge will do.
  task automatic cyc();
    int g;
    logic [N-1:0] er;
    entry_t e;
    #1;
    g  = -1;
    er = '0;
    if (q.size() < D) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (g < 0 && cv[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("ready", 32'(child_ready), 32'(er));
    check("uvalid", 32'(up_valid), 32'(q.size() != 0));
    check("count", 32'(event_count), 32'(cnt));
    if (q.size() != 0) begin
      check("uidx", 32'(up_index), 32'(q[0].index));
      check("udata", 32'(up_data), 32'(q[0].data));
    end else if (fresh) begin
      check("idx0", 32'(up_index), 32'd0);
      check("dat0", 32'(up_data), 32'd0);
    end
    if (q.size() != 0 && ur) begin
      void'(q.pop_front());
      cnt++;
      xfers++;
    end
    if (g >= 0) begin
      e.index = IDX_W'(g);
      e.data  = cd[g];
      q.push_back(e);
      rr    = (g + 1) % N;
      fresh = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N; i++) cd[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_uv", 32'(up_valid), 32'd0);
    check("rst_cnt", 32'(event_count), 32'd0);
    check("rst_rdy", 32'(child_ready), 32'd0);
    q.delete();
    rr    = 0;
    cnt   = 16'd0;
    fresh = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cv  = '0;
    ur  = 1'b0;
    cd  = '0;
    #2;
    do_reset();
    cv = '1;
    cyc();
    cv = '0;
    cyc();

    // single event from child 2
    cv = 5'b00100;
    ur = 1'b1;
    cd[2] = 8'hA5;
    cyc();
    cv = '0;
    repeat (3) cyc();
    check("single_cnt", 32'(event_count), 32'(cnt));

    // fairness with all children valid
    cv = '1;
    repeat (12) begin rnd_data(); cyc(); end
    cv = '0;
    repeat (3) cyc();

    // backpressure then drain
    ur = 1'b0;
    cv = '1;
    repeat (8) begin rnd_data(); cyc(); end
    cv = '0;
    ur = 1'b1;
    repeat (6) cyc();

    // full plus pop: no grant this cycle, grant next
    ur = 1'b0;
    cv = '1;
    repeat (5) begin rnd_data(); cyc(); end
    ur = 1'b1;
    cv = 5'b00010;
    cd[1] = 8'h3C;
    repeat (2) cyc();
    cv = '0;
    repeat (6) cyc();

    // random traffic
    repeat (300) begin
      cv = N'($urandom);
      ur = 1'($urandom);
      rnd_data();
      cyc();
    end

    // reset mid-stream with buffered entries
    cv = '0;
    ur = 1'b1;
    repeat (6) cyc();
    ur = 1'b0;
    cv = 5'b00001;
    repeat (3) begin rnd_data(); cyc(); end
    check("pre_rst_occ", 32'(up_valid), 32'd1);
    cv = '0;
    #3;
    do_reset();
    cyc();
    cv = 5'b01000;
    ur = 1'b1;
    cd[3] = 8'h5E;
    cyc();
    cv = '0;
    repeat (3) cyc();

    // counter wrap after 65537 transfers from reset
    do_reset();
    xfers = 0;
    cv = '1;
    ur = 1'b1;
    for (int t = 0; t < 70000 && xfers < 65537; t++) begin
      cd[0] = 8'(t);
      cyc();
    end
    check("wrap_xfers", 32'(xfers), 32'd65537);
    cv = '0;
    ur = 1'b0;
    cyc();
    check("wrap_cnt", 32'(event_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
